// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared definitions for the intersection phase sequencer and the light decoder.
//   phase_t    : 2-bit light phase encoding (HG=00, HY=01, CG=10, CY=11)
//   DW_DEFAULT : default width of duration inputs and remaining-time output
package traffic_phase_sequencer_pkg;

    localparam int unsigned DW_DEFAULT = 4;

    typedef enum logic [1:0] {
        HG = 2'b00,  // highway green
        HY = 2'b01,  // highway yellow
        CG = 2'b10,  // country green
        CY = 2'b11   // country yellow
    } phase_t;

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Control/status bundle between the sequencer and its neighbours.
//   master : sensor/timebase/config side, drives tick, car_sync, ped_req and
//            the three durations; observes the sequencer outputs
//   slave  : the sequencer itself
interface traffic_phase_sequencer_if #(
    parameter int unsigned DW = 4
);
    logic          tick;
    logic          car_sync;
    logic          ped_req;
    logic [DW-1:0] time_min_green;
    logic [DW-1:0] time_country;
    logic [DW-1:0] time_yellow;
    logic [1:0]    state;
    logic [DW-1:0] remaining;
    logic          phase_start;
    logic          ped_pending;
    logic          ped_served;

    modport master (
        output tick, car_sync, ped_req, time_min_green, time_country, time_yellow,
        input  state, remaining, phase_start, ped_pending, ped_served
    );

    modport slave (
        input  tick, car_sync, ped_req, time_min_green, time_country, time_yellow,
        output state, remaining, phase_start, ped_pending, ped_served
    );
endinterface

// File: rtl/traffic_phase_sequencer_counter.sv
// Phase interval down-counter.
//   clock, reset : clock, async active-high reset (remaining -> 0)
//   tick         : timebase enable for the decrement
//   load         : load load_value (zero is loaded as one); wins over decrement
//   remaining    : registered ticks left, saturates at 0
//   expired_c    : remaining <= 1 (combinational)
module phase_interval_counter #(
    parameter int unsigned DW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          load,
    input  logic [DW-1:0] load_value,
    output logic [DW-1:0] remaining,
    output logic          expired_c
);

    // Load takes priority; otherwise tick-qualified saturating decrement.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= (load_value == '0) ? DW'(1) : load_value;
        end else if (tick && (remaining != '0)) begin
            remaining <= remaining - DW'(1);
        end
    end

    assign expired_c = (remaining <= DW'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Four-phase highway/country intersection sequencer with pedestrian latch.
//   clock, reset : system clock, async active-high reset (back to HG, timer 0)
//   bus (slave)  : tick/car_sync/ped_req/durations in; state, remaining,
//                  phase_start, ped_pending, ped_served out (all registered)
module traffic_phase_sequencer
    import traffic_phase_sequencer_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    traffic_phase_sequencer_if.slave    bus
);

    phase_t        state_q;
    phase_t        next_state_c;
    logic          load_c;
    logic [DW-1:0] load_value_c;
    logic          expired_c;
    logic          enter_cg_c;
    logic [DW-1:0] remaining_q;
    logic          phase_start_q;
    logic          ped_pending_q;
    logic          ped_served_q;

    phase_interval_counter #(.DW(DW)) u_counter (
        .clock      (clock),
        .reset      (reset),
        .tick       (bus.tick),
        .load       (load_c),
        .load_value (load_value_c),
        .remaining  (remaining_q),
        .expired_c  (expired_c)
    );

    // Phase state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HG;
        end else begin
            state_q <= next_state_c;
        end
    end

    // Next phase and timer load; transitions only on tick edges.
    always_comb begin
        next_state_c = state_q;
        load_c       = 1'b0;
        load_value_c = '0;
        if (bus.tick) begin
            unique case (state_q)
                HG: if (expired_c && (bus.car_sync || ped_pending_q)) begin
                    next_state_c = HY;
                    load_c       = 1'b1;
                    load_value_c = bus.time_yellow;
                end
                HY: if (expired_c) begin
                    next_state_c = CG;
                    load_c       = 1'b1;
                    load_value_c = bus.time_country;
                end
                CG: if (expired_c || !bus.car_sync) begin
                    next_state_c = CY;
                    load_c       = 1'b1;
                    load_value_c = bus.time_yellow;
                end
                CY: if (expired_c) begin
                    next_state_c = HG;
                    load_c       = 1'b1;
                    load_value_c = bus.time_min_green;
                end
                default: ;
            endcase
        end
    end

    assign enter_cg_c = (state_q == HY) && (next_state_c == CG);

    // Pedestrian latch and one-cycle status pulses; a new request wins over the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_start_q <= 1'b0;
            ped_pending_q <= 1'b0;
            ped_served_q  <= 1'b0;
        end else begin
            phase_start_q <= (next_state_c != state_q);
            ped_served_q  <= enter_cg_c && ped_pending_q;
            if (bus.ped_req) begin
                ped_pending_q <= 1'b1;
            end else if (enter_cg_c) begin
                ped_pending_q <= 1'b0;
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.remaining   = remaining_q;
    assign bus.phase_start = phase_start_q;
    assign bus.ped_pending = ped_pending_q;
    assign bus.ped_served  = ped_served_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed, table-driven bench for traffic_phase_sequencer.
module tb_traffic_phase_sequencer;
    import traffic_phase_sequencer_pkg::*;

    localparam int unsigned DW = 4;

    typedef struct {
        logic       tick;
        logic       car;
        logic       ped;
        logic [3:0] ty;
        logic [1:0] st;
        logic [3:0] rem;
        logic       ps;
        logic       pend;
        logic       srv;
    } vec_t;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    vec_t vecs[$];

    traffic_phase_sequencer_if #(.DW(DW)) bus ();

    traffic_phase_sequencer #(.DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] rem,
                             input logic ps, input logic pend, input logic srv);
        check({tag, ".state"},       int'(bus.state),       int'(st));
        check({tag, ".remaining"},   int'(bus.remaining),   int'(rem));
        check({tag, ".phase_start"}, int'(bus.phase_start), int'(ps));
        check({tag, ".ped_pending"}, int'(bus.ped_pending), int'(pend));
        check({tag, ".ped_served"},  int'(bus.ped_served),  int'(srv));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic tick, input logic car, input logic ped, input logic [3:0] ty,
                       input logic [1:0] st, input logic [3:0] rem,
                       input logic ps, input logic pend, input logic srv);
        vec_t v;
        v.tick = tick; v.car = car; v.ped = ped; v.ty = ty;
        v.st = st; v.rem = rem; v.ps = ps; v.pend = pend; v.srv = srv;
        vecs.push_back(v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.car_sync = 1'b0;
        bus.ped_req = 1'b0;
        bus.time_min_green = 4'd3;
        bus.time_country = 4'd5;
        bus.time_yellow = 4'd2;

        // Steady traffic: min green 3, yellow 2, country 5
        add(1,1,0,2, HY,2,1,0,0);
        add(0,1,0,2, HY,2,0,0,0);
        add(1,1,0,2, HY,1,0,0,0);
        add(1,1,0,2, CG,5,1,0,0);
        add(1,1,0,2, CG,4,0,0,0);
        add(1,1,0,2, CG,3,0,0,0);
        add(1,1,0,2, CG,2,0,0,0);
        add(1,1,0,2, CG,1,0,0,0);
        add(1,1,0,2, CY,2,1,0,0);
        add(1,1,0,2, CY,1,0,0,0);
        add(1,1,0,2, HG,3,1,0,0);
        add(1,1,0,2, HG,2,0,0,0);
        add(1,1,0,2, HG,1,0,0,0);
        add(1,1,0,2, HY,2,1,0,0);
        add(1,1,0,2, HY,1,0,0,0);
        add(1,1,0,2, CG,5,1,0,0);
        add(1,1,0,2, CG,4,0,0,0);
        // car leaves mid-CG: early exit on the next tick
        add(0,0,0,2, CG,4,0,0,0);
        add(1,0,0,2, CY,2,1,0,0);
        add(1,0,0,2, CY,1,0,0,0);
        add(1,0,0,2, HG,3,1,0,0);
        add(1,0,0,2, HG,2,0,0,0);
        add(1,0,0,2, HG,1,0,0,0);
        add(1,0,0,2, HG,0,0,0,0);
        add(1,0,0,2, HG,0,0,0,0);
        // pedestrian request while idle in HG
        add(0,0,1,2, HG,0,0,1,0);
        add(1,0,0,2, HY,2,1,1,0);
        add(1,0,0,2, HY,1,0,1,0);
        add(1,0,0,2, CG,5,1,0,1);
        add(1,0,0,2, CY,2,1,0,0);
        add(1,0,0,2, CY,1,0,0,0);
        add(1,0,0,2, HG,3,1,0,0);
        // request during HG, then another on the HY->CG edge
        add(1,0,1,2, HG,2,0,1,0);
        add(1,0,0,2, HG,1,0,1,0);
        add(1,0,0,2, HY,2,1,1,0);
        add(1,0,0,2, HY,1,0,1,0);
        add(1,0,1,2, CG,5,1,1,1);
        add(1,0,0,2, CY,2,1,1,0);
        add(1,0,0,2, CY,1,0,1,0);
        add(1,0,0,2, HG,3,1,1,0);
        add(1,0,0,2, HG,2,0,1,0);
        add(1,0,0,2, HG,1,0,1,0);
        add(1,0,0,2, HY,2,1,1,0);
        add(1,0,0,2, HY,1,0,1,0);
        // zero yellow duration loads as one tick
        add(1,1,0,0, CG,5,1,0,1);
        add(1,1,0,0, CG,4,0,0,0);
        add(1,1,0,0, CG,3,0,0,0);
        add(1,1,0,0, CG,2,0,0,0);
        add(1,1,0,0, CG,1,0,0,0);
        add(1,1,0,0, CY,1,1,0,0);
        add(1,1,0,0, HG,3,1,0,0);
        add(1,1,0,0, HG,2,0,0,0);
        add(1,1,0,0, HG,1,0,0,0);
        add(1,1,0,0, HY,1,1,0,0);
        add(1,1,0,0, CG,5,1,0,0);
        add(1,1,0,0, CG,4,0,0,0);
        add(0,1,1,0, CG,4,0,1,0);

        // Reset state while reset is held
        #2;
        check_all("reset", HG, 4'd0, 1'b0, 1'b0, 1'b0);
        #10;
        reset = 1'b0;
        #1;

        // Idle: no car, no request, twenty ticks
        bus.tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_all($sformatf("idle%0d", i), HG, 4'd0, 1'b0, 1'b0, 1'b0);
        end

        // Table-driven sequence
        foreach (vecs[i]) begin
            bus.tick = vecs[i].tick;
            bus.car_sync = vecs[i].car;
            bus.ped_req = vecs[i].ped;
            bus.time_yellow = vecs[i].ty;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].rem,
                      vecs[i].ps, vecs[i].pend, vecs[i].srv);
        end

        // Asynchronous reset mid-CG with a pending request
        bus.tick = 1'b0;
        bus.ped_req = 1'b0;
        bus.car_sync = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", HG, 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        step();
        check_all("post_reset", HG, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Sequences the four light phases of the highway/country intersection and owns the phase interval timer. Latches pedestrian crossing requests and enforces a minimum highway green. Drives the 2-bit light state consumed by the light decoder and the remaining-time value consumed by the BCD display path. Sits between the car sensor synchroniser and the light and display decoders, replacing separate timer/next-state sequencing.

Parameters:
DW, 4, width of duration inputs and remaining-time output (ticks)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; forces the reset state immediately
tick  in  1  one-cycle timebase enable; all timing is counted in ticks
car_sync  in  1  synchronised country-road car present (level)
ped_req  in  1  pedestrian request pulse, any width, not synchronised by this block
time_min_green  in  DW  minimum highway-green duration, ticks
time_country  in  DW  maximum country-green duration, ticks
time_yellow  in  DW  yellow duration for both roads, ticks
state  out  2  current phase: HG=00, HY=01, CG=10, CY=11
remaining  out  DW  ticks left in the current timed interval
phase_start  out  1  one-cycle pulse, first cycle a new state is visible
ped_pending  out  1  latched pedestrian request not yet served
ped_served  out  1  one-cycle pulse when a pending request is served

Behaviour:
- Reset (asynchronous, active-high): state=HG, remaining=0, ped_pending=0, phase_start=0, ped_served=0. Min green is treated as already satisfied.
- All registers are updated only on clock edges. Counting and transitions happen only on edges where tick=1. With tick=0, only the ped latch and pulse clearing act.
- Duration load: on entry to a phase, remaining <= duration input sampled at that edge. A duration of 0 is loaded as 1.
- Expiry test: a tick with remaining<=1.
- HG:
  - On tick, if remaining<=1 and (car_sync or ped_pending): go to HY and load time_yellow.
  - Else on tick, if remaining>0: remaining decrements, saturating at 0 in HG.
- HY: on tick, if expired, go to CG and load time_country; else decrement.
- CG:
  - On tick, if expired or car_sync=0: go to CY and load time_yellow.
  - Else decrement.
- CY: on tick, if expired, go to HG and load time_min_green; else decrement.
- Timed phases last exactly N ticks, with N the loaded value. There is no early exit in HY or CY.
- ped_pending:
  - Set on any cycle ped_req=1.
  - Cleared on the edge that enters CG.
  - If ped_req=1 on that same edge, set wins and the request stays pending for the next cycle.
- ped_served: registered pulse, high for exactly the one cycle after the HY->CG edge, and only if ped_pending was 1 before that edge.
- phase_start: registered pulse, high for exactly the one cycle in which state first shows a new value. Never high after reset alone.
- Latency: the transition edge is the tick edge. New state, remaining and pulses are visible on the following cycle.
- Duration inputs are sampled only at load edges. Changes mid-phase have no effect until the next entry.
- car_sync dropping in HY has no effect; HY always completes.
- Reset mid-phase: immediate return to HG with remaining=0. A pending ped request is discarded.
- Unreachable states do not exist (2-bit full encoding).

Decomposition:
- Shared package: phase encoding constants (HG, HY, CG, CY) and the DW default. The light decoder and this block both use these constants.
- Sub-module: phase_interval_counter. DW-bit down-counter with load (zero maps to 1), tick-qualified decrement saturating at 0, and an expiry flag (remaining<=1). The FSM, ped latch and pulse generation stay in the top.

Test Plan:
- Reset, then car_sync=0, ped_req=0, 20 ticks -> state stays 00, remaining=0, phase_start never high.
- time_min_green=3, time_yellow=2, time_country=5, car_sync=1 steady from reset:
  - Timeline: HY at tick 1, CG after 2 more ticks, CY after 5 ticks, HG after 2 ticks.
  - In HG, remaining loads 3; next HY after 3 ticks.
  - phase_start is one cycle at each change.
- In CG with remaining=4, drop car_sync before the next tick -> CY on that tick, remaining=time_yellow.
- car_sync=0, one-cycle ped_req in HG -> ped_pending=1. Sequence HY->CG follows. ped_served pulses once on CG entry and ped_pending=0. CG exits to CY on the next tick, since car_sync=0.
- ped_req asserted on the HY->CG edge -> ped_served pulses, ped_pending remains 1, and the next HG min green expiry triggers HY.
- time_yellow=0 -> HY lasts exactly 1 tick. Assert reset mid-CG between clock edges -> state=00 and remaining=0 immediately; ped_pending=0.
